// File: rtl/bka11_rr_adder_arbiter.sv
// Round-robin arbitrated access to a shared 11-bit Brent-Kung adder.
// One request is granted per cycle. Its operands pass through the adder
// combinationally, and the 12-bit sum plus the requester tag are captured
// in a single output register that uses valid/ready handshaking.

// 11-bit Brent-Kung parallel-prefix adder with carry-in; bit 11 of sum_o is carry-out.
module UBPriBKA_10_0 (
    input  logic [10:0] x_i,
    input  logic [10:0] y_i,
    input  logic        cin_i,
    output logic [11:0] sum_o
);

    logic [10:0] p;
    logic [10:0] g;
    logic [10:0] gg;
    logic [10:0] pp;

    // Prefix tree: carry-in is folded into bit 0's generate, then an up-sweep
    // and a down-sweep leave gg[i] as the carry out of bit i.
    always_comb begin
        p     = x_i ^ y_i;
        g     = x_i & y_i;
        gg    = g;
        pp    = p;
        gg[0] = g[0] | (p[0] & cin_i);
        for (int unsigned d = 1; d < 11; d = d * 2) begin
            for (int unsigned i = 2 * d - 1; i < 11; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end
        for (int unsigned d = 4; d >= 1; d = d / 2) begin
            for (int unsigned i = 3 * d - 1; i < 11; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i - d]);
            end
        end
        sum_o[0] = p[0] ^ cin_i;
        for (int unsigned i = 1; i < 11; i++) begin
            sum_o[i] = p[i] ^ gg[i - 1];
        end
        sum_o[11] = gg[10];
    end

endmodule

module bka11_rr_adder_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*11-1:0]   req_x,
    input  logic [NREQ*11-1:0]   req_y,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [11:0]          res_sum,
    output logic [IDW-1:0]       res_id,
    output logic                 busy
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            res_valid_q, res_valid_d;
    logic [11:0]     res_sum_q, res_sum_d;
    logic [IDW-1:0]  res_id_q, res_id_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic            can_accept;
    logic            transfer;
    int unsigned     idx;
    int unsigned     base;
    logic [10:0]     sel_x;
    logic [10:0]     sel_y;
    logic            sel_cin;
    logic [11:0]     add_sum;

    // Round-robin scan starting at ptr_q: the first valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any    = 1'b1;
                gnt_id     = IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    // Route the granted requester's operands into the shared adder.
    always_comb begin
        base    = 11 * 32'(gnt_id);
        sel_x   = req_x[base +: 11];
        sel_y   = req_y[base +: 11];
        sel_cin = req_cin[gnt_id];
    end

    UBPriBKA_10_0 u_adder (
        .x_i   (sel_x),
        .y_i   (sel_y),
        .cin_i (sel_cin),
        .sum_o (add_sum)
    );

    assign can_accept = !res_valid_q || res_ready;
    assign transfer   = gnt_any && can_accept;
    assign req_ready  = grant & {NREQ{can_accept & ~rst}};
    assign busy       = res_valid_q | (|req_valid);
    assign res_valid  = res_valid_q;
    assign res_sum    = res_sum_q;
    assign res_id     = res_id_q;

    // Next state: load on transfer (also covers drain+accept), otherwise drain or hold.
    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        if (transfer) begin
            res_valid_d = 1'b1;
            res_sum_d   = add_sum;
            res_id_d    = gnt_id;
            ptr_d       = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
        end
    end

endmodule

// File: tb/tb_bka11_rr_adder_arbiter.sv
// Self-checking bench for bka11_rr_adder_arbiter: a vector table, directed
// multi-cycle sequences and a cycle-level reference model with a result scoreboard.
module tb_bka11_rr_adder_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*11-1:0]   req_x;
    logic [NREQ*11-1:0]   req_y;
    logic [NREQ-1:0]      req_cin;
    logic                 res_valid;
    logic                 res_ready;
    logic [11:0]          res_sum;
    logic [IDW-1:0]       res_id;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic [10:0] x;
        logic [10:0] y;
        logic        cin;
        logic [11:0] sum;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [11:0]    sum;
    } exp_t;

    exp_t sb[$];

    // Reference model state, updated at every falling edge.
    logic           m_valid = 1'b0;
    int             m_ptr   = 0;

    bka11_rr_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int id, input logic [10:0] x, input logic [10:0] y, input logic c);
        req_x[11*id +: 11] = x;
        req_y[11*id +: 11] = y;
        req_cin[id]        = c;
    endtask

    // Reference model: checks grants, valid and busy each cycle, pushes the
    // expected result of each accepted request and pops it when consumed.
    always @(negedge clk) begin
        int             gi;
        int             ix;
        logic [NREQ-1:0] exp_rdy;
        logic [10:0]    xv, yv;
        exp_t           e;
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            sb.delete();
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", res_valid, 0);
        end else begin
            gi      = -1;
            exp_rdy = '0;
            if (!m_valid || res_ready) begin
                for (int k = 0; k < NREQ; k++) begin
                    ix = (m_ptr + k) % NREQ;
                    if (gi < 0 && req_valid[ix]) gi = ix;
                end
            end
            if (gi >= 0) exp_rdy[gi] = 1'b1;
            chk("mon_ready", req_ready, exp_rdy);
            chk("mon_valid", res_valid, m_valid);
            chk("mon_busy", busy, m_valid | (|req_valid));
            if (m_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_sum", res_sum, e.sum);
                    chk("sb_id", res_id, e.id);
                end
            end
            if (gi >= 0) begin
                xv    = req_x[11*gi +: 11];
                yv    = req_y[11*gi +: 11];
                e.id  = IDW'(gi);
                e.sum = {1'b0, xv} + {1'b0, yv} + {11'b0, req_cin[gi]};
                sb.push_back(e);
                m_ptr   = (gi + 1) % NREQ;
                m_valid = 1'b1;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        vec_t tbl[8];
        logic [NREQ-1:0] onehot;
        tbl[0] = '{0, 11'h7FF, 11'h001, 1'b0, 12'h800};
        tbl[1] = '{2, 11'h7FF, 11'h7FF, 1'b1, 12'hFFF};
        tbl[2] = '{1, 11'h000, 11'h000, 1'b0, 12'h000};
        tbl[3] = '{3, 11'h000, 11'h000, 1'b1, 12'h001};
        tbl[4] = '{1, 11'h555, 11'h2AA, 1'b0, 12'h7FF};
        tbl[5] = '{1, 11'h555, 11'h2AB, 1'b0, 12'h800};
        tbl[6] = '{0, 11'h400, 11'h400, 1'b1, 12'h801};
        tbl[7] = '{3, 11'h123, 11'h456, 1'b1, 12'h57A};

        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_cin   = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", res_valid, 0);
        chk("reset_sum", res_sum, 0);
        chk("reset_id", res_id, 0);
        chk("reset_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Single isolated requests: accept, result next cycle, then empty.
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            req_valid = '0;
            set_req(tbl[v].id, tbl[v].x, tbl[v].y, tbl[v].cin);
            req_valid[tbl[v].id] = 1'b1;
            res_ready = 1'b1;
            @(negedge clk);
            onehot = '0;
            onehot[tbl[v].id] = 1'b1;
            chk("tbl_ready", req_ready, onehot);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk("tbl_valid", res_valid, 1);
            chk("tbl_sum", res_sum, tbl[v].sum);
            chk("tbl_id", res_id, tbl[v].id);
            @(posedge clk); #1;
            @(negedge clk);
            chk("tbl_drained", res_valid, 0);
        end

        // All requesters valid, consumer always ready: strict rotation, no bubbles.
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 11'(i * 16'h101), 11'(16'h0F0 + i), i[0]);
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            onehot = '0;
            onehot[k % NREQ] = 1'b1;
            chk("rr_ready", req_ready, onehot);
            if (k > 0) begin
                chk("rr_valid", res_valid, 1);
                chk("rr_id", res_id, (k - 1) % NREQ);
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_last_id", res_id, 1);

        // Grant to req2 moves the pointer to 3.
        @(posedge clk); #1;
        set_req(2, 11'h7FF, 11'h7FF, 1'b1);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("ptr_req2", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("ptr_next3", req_ready, 4'b1000);
        chk("carry_sum", res_sum, 12'hFFF);
        chk("carry_id", res_id, 2);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("ptr_id3", res_id, 3);

        // Backpressure: result held, no grants while stalled.
        @(posedge clk); #1;
        set_req(0, 11'h0AA, 11'h055, 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("bp_first", req_ready, 4'b0001);
        @(posedge clk); #1;
        set_req(1, 11'h300, 11'h0FF, 1'b1);
        req_valid = 4'b0010;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", req_ready, 0);
            chk("bp_valid", res_valid, 1);
            chk("bp_sum", res_sum, 12'h0FF);
            chk("bp_id", res_id, 0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b0;
        @(negedge clk);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_res_sum", res_sum, 12'h400);
        chk("bp_res_id", res_id, 1);

        // Asynchronous reset with a result pending.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_sum", res_sum, 0);
        chk("arst_id", res_id, 0);
        chk("arst_ready", req_ready, 0);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("arst_hold_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_ptr0", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("arst_first_id", res_id, 0);

        // Random traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) set_req(i, 11'($urandom), 11'($urandom), 1'($urandom));
            req_valid = NREQ'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_valid", res_valid, 0);
        chk("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
